// File: rtl/bram_dpm_param_if.sv
// Port bundle for bram_dpm_param: two read/write ports, clear-engine control and collision flag.
// The master side is the client (transfer engine / host), the slave side is the RAM.
interface bram_dpm_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 7
);
  logic                clr_start;
  logic                clr_busy;
  logic                clr_done;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   addr_b;
  logic                wr_a;
  logic                wr_b;
  logic [DATA_W/8-1:0] be_a;
  logic [DATA_W/8-1:0] be_b;
  logic [DATA_W-1:0]   datain_a;
  logic [DATA_W-1:0]   datain_b;
  logic [DATA_W-1:0]   dataout_a;
  logic [DATA_W-1:0]   dataout_b;
  logic                collision;

  modport master (
    output clr_start, addr_a, addr_b, wr_a, wr_b, be_a, be_b, datain_a, datain_b,
    input  clr_busy, clr_done, dataout_a, dataout_b, collision
  );

  modport slave (
    input  clr_start, addr_a, addr_b, wr_a, wr_b, be_a, be_b, datain_a, datain_b,
    output clr_busy, clr_done, dataout_a, dataout_b, collision
  );
endinterface

// File: rtl/bram_dpm_param.sv
// Parametrised true dual-port RAM with byte enables, A-wins write arbitration and a clear engine.
// Optional macro BRAM_DPM_OUTREG_EN adds one output register stage on both read ports.
module bram_dpm_param #(
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 66,
  parameter int                ADDR_W    = 7,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  bram_dpm_param_if.slave   bus
);

  localparam int                NB      = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdA_q, rdA_d, rdB_q, rdB_d;
  logic              col_q, col_d;

  logic              busy;
  logic              inA, inB, weA, weB, sameAddr;
  logic [DATA_W-1:0] oldA, oldB, mergedA, mergedB;

  function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldW,
                                                   input logic [DATA_W-1:0] newW,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = oldW;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = newW[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // Both merged words apply B first and A last, so A owns every byte it enables on a shared address.
  always_comb begin
    inA      = ({1'b0, bus.addr_a} < DEPTH_L);
    inB      = ({1'b0, bus.addr_b} < DEPTH_L);
    weA      = bus.wr_a & inA & ~busy;
    weB      = bus.wr_b & inB & ~busy;
    sameAddr = (bus.addr_a == bus.addr_b);
    oldA     = inA ? mem[bus.addr_a] : '0;
    oldB     = inB ? mem[bus.addr_b] : '0;

    mergedA = oldA;
    if (weB && sameAddr) mergedA = mergeBytes(mergedA, bus.datain_b, bus.be_b);
    if (weA)             mergedA = mergeBytes(mergedA, bus.datain_a, bus.be_a);

    mergedB = oldB;
    if (weB)             mergedB = mergeBytes(mergedB, bus.datain_b, bus.be_b);
    if (weA && sameAddr) mergedB = mergeBytes(mergedB, bus.datain_a, bus.be_a);

    rdA_d = weA ? mergedA : oldA;
    rdB_d = weB ? mergedB : oldB;
    col_d = weA & weB & sameAddr;
  end

  // Reset blocks array writes so an aborted clear leaves the current location untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        mem[cnt_q] <= CLEAR_VAL;
      end else begin
        if (weA) mem[bus.addr_a] <= mergedA;
        if (weB) mem[bus.addr_b] <= mergedB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdA_q   <= '0;
      rdB_q   <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdA_q   <= rdA_d;
      rdB_q   <= rdB_d;
      col_q   <= col_d;
    end
  end

  assign bus.clr_busy  = busy;
  assign bus.clr_done  = (state_q == DONE);
  assign bus.collision = col_q;

`ifdef BRAM_DPM_OUTREG_EN
  logic [DATA_W-1:0] outA_q, outB_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      outA_q <= '0;
      outB_q <= '0;
    end else begin
      outA_q <= rdA_q;
      outB_q <= rdB_q;
    end
  end

  assign bus.dataout_a = outA_q;
  assign bus.dataout_b = outB_q;
`else
  assign bus.dataout_a = rdA_q;
  assign bus.dataout_b = rdB_q;
`endif

endmodule

// File: tb/tb_bram_dpm_param.sv
// Self-checking bench for bram_dpm_param: constant vector table, hand sequences for the clear
// engine and reset abort, and randomized traffic against an array-level reference model.
module tb_bram_dpm_param;

  localparam int          DATA_W    = 64;
  localparam int          DEPTH     = 66;
  localparam int          ADDR_W    = 7;
  localparam logic [63:0] CLEAR_VAL = 64'h0;
`ifdef BRAM_DPM_OUTREG_EN
  localparam int          LAT       = 2;
`else
  localparam int          LAT       = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  bram_dpm_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_dpm_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_VAL(CLEAR_VAL), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addrA;
    logic        wrA;
    logic [7:0]  beA;
    logic [63:0] dA;
    logic [6:0]  addrB;
    logic        wrB;
    logic [7:0]  beB;
    logic [63:0] dB;
    logic        clr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [63:0] expA;
    logic [63:0] expB;
    logic        expCol;
  } vec_t;

  int nVec = 0;
  int nMis = 0;

  logic [63:0] mdlMem [DEPTH];
  bit          mdlBusy = 0;
  bit          mdlDone = 0;
  int          mdlIdx  = 0;
  logic [63:0] pipeA = '0, pipeB = '0;
  logic [63:0] expOutA, expOutB;
  logic        expCol;

  function automatic logic [63:0] pattern(input int i);
    return {32'hCAFE0000 + 32'(i), 32'h12340000 + 32'(i * 7)};
  endfunction

  function automatic stim_t idleStim(input logic [6:0] a, input logic [6:0] b);
    stim_t s;
    s = '{addrA: a, wrA: 1'b0, beA: 8'h00, dA: 64'h0, addrB: b, wrB: 1'b0, beB: 8'h00, dB: 64'h0, clr: 1'b0};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: whole-array semantics applied once per clock edge.
  task automatic modelEdge(input stim_t s, input bit rst);
    bit          inA, inB, wa, wb;
    logic [63:0] oldA, oldB, newA, newB;
    if (rst) begin
      mdlBusy = 0;
      mdlDone = 0;
      pipeA   = '0;
      pipeB   = '0;
      expOutA = '0;
      expOutB = '0;
      expCol  = 1'b0;
      return;
    end
    inA  = (int'(s.addrA) < DEPTH);
    inB  = (int'(s.addrB) < DEPTH);
    wa   = s.wrA && inA && !mdlBusy;
    wb   = s.wrB && inB && !mdlBusy;
    oldA = inA ? mdlMem[s.addrA] : 64'h0;
    oldB = inB ? mdlMem[s.addrB] : 64'h0;
    if (wb) for (int i = 0; i < 8; i++) if (s.beB[i]) mdlMem[s.addrB][8*i +: 8] = s.dB[8*i +: 8];
    if (wa) for (int i = 0; i < 8; i++) if (s.beA[i]) mdlMem[s.addrA][8*i +: 8] = s.dA[8*i +: 8];
    newA   = wa ? mdlMem[s.addrA] : oldA;
    newB   = wb ? mdlMem[s.addrB] : oldB;
    expCol = wa && wb && (s.addrA == s.addrB);
    if (mdlBusy) begin
      mdlMem[mdlIdx] = CLEAR_VAL;
      mdlIdx++;
      if (mdlIdx == DEPTH) begin
        mdlBusy = 0;
        mdlDone = 1;
      end
    end else if (mdlDone) begin
      mdlDone = 0;
    end else if (s.clr) begin
      mdlBusy = 1;
      mdlIdx  = 0;
    end
    if (LAT == 2) begin
      expOutA = pipeA;
      expOutB = pipeB;
      pipeA   = newA;
      pipeB   = newB;
    end else begin
      expOutA = newA;
      expOutB = newB;
    end
  endtask

  task automatic applyStimulus(input stim_t s, input bit rst);
    reset         = rst;
    bus.addr_a    = s.addrA;
    bus.wr_a      = s.wrA;
    bus.be_a      = s.beA;
    bus.datain_a  = s.dA;
    bus.addr_b    = s.addrB;
    bus.wr_b      = s.wrB;
    bus.be_b      = s.beB;
    bus.datain_b  = s.dB;
    bus.clr_start = s.clr;
    @(posedge clk);
    #1;
    modelEdge(s, rst);
    checkOutput("mdlDoutA", bus.dataout_a, expOutA);
    checkOutput("mdlDoutB", bus.dataout_b, expOutB);
    checkOutput("mdlCollision", {63'h0, bus.collision}, {63'h0, expCol});
    checkOutput("mdlBusy", {63'h0, bus.clr_busy}, {63'h0, mdlBusy});
    checkOutput("mdlDone", {63'h0, bus.clr_done}, {63'h0, mdlDone});
  endtask

  task automatic readAddr(input logic [6:0] a, output logic [63:0] d);
    for (int k = 0; k < LAT; k++) applyStimulus(idleStim(a, 7'd127), 1'b0);
    d = bus.dataout_a;
  endtask

  vec_t  vecs [8];
  stim_t s;
  int    busyCnt;
  bit    doneSeen;
  logic [63:0] rd;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdlMem[i] = 64'h0;

    for (int k = 0; k < 3; k++) applyStimulus(idleStim(7'd127, 7'd127), 1'b1);
    checkOutput("resetDoutA", bus.dataout_a, 64'h0);
    checkOutput("resetDoutB", bus.dataout_b, 64'h0);
    checkOutput("resetBusy", {63'h0, bus.clr_busy}, 64'h0);
    checkOutput("resetDone", {63'h0, bus.clr_done}, 64'h0);
    checkOutput("resetCollision", {63'h0, bus.collision}, 64'h0);

    // Initial clear; a port write and a second start are injected mid-clear.
    s = idleStim(7'd127, 7'd127);
    s.clr = 1'b1;
    applyStimulus(s, 1'b0);
    busyCnt  = 0;
    doneSeen = 0;
    for (int c = 0; c < 200 && !doneSeen; c++) begin
      if (bus.clr_busy) busyCnt++;
      s = idleStim(7'd127, 7'd127);
      if (c == 10) begin
        s.addrA = 7'd3;
        s.wrA   = 1'b1;
        s.beA   = 8'hFF;
        s.dA    = 64'hFFFF_FFFF_FFFF_FFFF;
        s.clr   = 1'b1;
      end
      if (c == 30) s.clr = 1'b1;
      applyStimulus(s, 1'b0);
      if (bus.clr_done) doneSeen = 1;
    end
    checkOutput("clearBusyCycles", 64'(busyCnt), 64'd66);
    checkOutput("clearDoneSeen", {63'h0, doneSeen}, 64'h1);
    s = idleStim(7'd127, 7'd127);
    s.clr = 1'b1;
    applyStimulus(s, 1'b0);
    checkOutput("clrStartInDoneIgnored", {63'h0, bus.clr_busy}, 64'h0);
    readAddr(7'd3, rd);
    checkOutput("busyWriteLost", rd, CLEAR_VAL);
    for (int i = 0; i < DEPTH + LAT; i++) applyStimulus(idleStim(7'(i), 7'(DEPTH - 1 - (i % DEPTH))), 1'b0);

    vecs[0] = '{s: '{7'd5, 1'b1, 8'hFF, 64'h1122334455667788, 7'd5, 1'b0, 8'h00, 64'h0, 1'b0},
                expA: 64'h1122334455667788, expB: 64'h0, expCol: 1'b0};
    vecs[1] = '{s: '{7'd5, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 7'd5, 1'b0, 8'h00, 64'h0, 1'b0},
                expA: 64'h11223344AAAAAAAA, expB: 64'h1122334455667788, expCol: 1'b0};
    vecs[2] = '{s: '{7'd5, 1'b0, 8'h00, 64'h0, 7'd5, 1'b0, 8'h00, 64'h0, 1'b0},
                expA: 64'h11223344AAAAAAAA, expB: 64'h11223344AAAAAAAA, expCol: 1'b0};
    vecs[3] = '{s: '{7'd9, 1'b1, 8'hF0, 64'hFFFFFFFF00000000, 7'd9, 1'b1, 8'hFF, 64'h0000000012345678, 1'b0},
                expA: 64'hFFFFFFFF12345678, expB: 64'hFFFFFFFF12345678, expCol: 1'b1};
    vecs[4] = '{s: '{7'd9, 1'b0, 8'h00, 64'h0, 7'd9, 1'b0, 8'h00, 64'h0, 1'b0},
                expA: 64'hFFFFFFFF12345678, expB: 64'hFFFFFFFF12345678, expCol: 1'b0};
    vecs[5] = '{s: '{7'd70, 1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF, 7'd70, 1'b0, 8'h00, 64'h0, 1'b0},
                expA: 64'h0, expB: 64'h0, expCol: 1'b0};
    vecs[6] = '{s: '{7'd65, 1'b0, 8'h00, 64'h0, 7'd65, 1'b1, 8'hFF, 64'h0123456789ABCDEF, 1'b0},
                expA: 64'h0, expB: 64'h0123456789ABCDEF, expCol: 1'b0};
    vecs[7] = '{s: '{7'd5, 1'b1, 8'h00, 64'h5555555555555555, 7'd66, 1'b0, 8'h00, 64'h0, 1'b0},
                expA: 64'h11223344AAAAAAAA, expB: 64'h0, expCol: 1'b0};

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].s, 1'b0);
      checkOutput($sformatf("tblCol%0d", v), {63'h0, bus.collision}, {63'h0, vecs[v].expCol});
      if (LAT == 2) begin
        s = vecs[v].s;
        s.wrA = 1'b0;
        s.wrB = 1'b0;
        applyStimulus(s, 1'b0);
      end
      checkOutput($sformatf("tblDoutA%0d", v), bus.dataout_a, vecs[v].expA);
      checkOutput($sformatf("tblDoutB%0d", v), bus.dataout_b, vecs[v].expB);
    end
    readAddr(7'd70, rd);
    checkOutput("outOfRangeRead", rd, 64'h0);

    for (int n = 0; n < 600; n++) begin
      s.addrA = 7'($urandom_range(0, 71));
      s.addrB = ($urandom_range(0, 3) == 0) ? s.addrA : 7'($urandom_range(0, 71));
      s.wrA   = 1'($urandom_range(0, 1));
      s.wrB   = 1'($urandom_range(0, 1));
      s.beA   = 8'($urandom);
      s.beB   = 8'($urandom);
      s.dA    = {$urandom, $urandom};
      s.dB    = {$urandom, $urandom};
      s.clr   = ($urandom_range(0, 149) == 0);
      applyStimulus(s, 1'b0);
    end

    for (int c = 0; c < 200 && (mdlBusy || mdlDone); c++) applyStimulus(idleStim(7'd127, 7'd127), 1'b0);
    checkOutput("idleBeforeAbort", {63'h0, bus.clr_busy}, 64'h0);

    // Fill with a pattern, start a clear, reset with the counter at 10.
    for (int i = 0; i < DEPTH; i++) begin
      s = idleStim(7'(i), 7'd127);
      s.wrA = 1'b1;
      s.beA = 8'hFF;
      s.dA  = pattern(i);
      applyStimulus(s, 1'b0);
    end
    s = idleStim(7'd127, 7'd127);
    s.clr = 1'b1;
    applyStimulus(s, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(idleStim(7'd127, 7'd127), 1'b0);
    applyStimulus(idleStim(7'd127, 7'd127), 1'b1);
    checkOutput("abortBusy", {63'h0, bus.clr_busy}, 64'h0);
    for (int i = 0; i < DEPTH + LAT; i++) applyStimulus(idleStim(7'(i % DEPTH), 7'(DEPTH - 1 - (i % DEPTH))), 1'b0);
    readAddr(7'd0, rd);
    checkOutput("abortAddr0", rd, CLEAR_VAL);
    readAddr(7'd9, rd);
    checkOutput("abortAddr9", rd, CLEAR_VAL);
    readAddr(7'd10, rd);
    checkOutput("abortAddr10", rd, pattern(10));
    readAddr(7'd65, rd);
    checkOutput("abortAddr65", rd, pattern(65));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
